tiny32_intc: RTL and testbench

//  8-source interrupt controller feeding tiny32 interrupt[7:0] and consuming interrupt_ack[7:0].

---
 rtl/tiny32_intc.sv | 146 ++++++++++++++
 tb/tb_tiny32_intc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tiny32_intc.sv
// 8-source interrupt controller for tiny32: synchronise, latch, mask, one-hot request with ack/reti.
// Optional soft pending (SWSET register) is compiled in with `define TINY32_INTC_SOFT_IRQ_EN.
module tiny32_intc #(
  parameter logic [31:0] BASE_ADDRESS = 32'hE000_0000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  irq_in,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        nrd,
  input  logic [3:0]  nwr,
  output logic        sel,
  output logic        ready,
  output logic [7:0]  interrupt,
  input  logic [7:0]  interrupt_ack
);

  typedef enum logic [1:0] {StIdle, StRequest, StInService} state_e;

  state_e                       state_q, state_d;
  logic [SYNC_STAGES-1:0][7:0]  sync_q;
  logic [7:0] level_q, edge_pend_q, edge_pend_d, enable_q, edge_q;
  logic [7:0] irq_q, irq_d, active_q, active_d;
  logic [7:0] synced, rise, w1c, ack_clr, soft_pend, pending, cand, onehot, rdata;
  logic [2:0] reg_idx;
  logic       wr_en;
  logic       unused_bits;

  assign unused_bits = ^{data_in[31:8], nwr[3:1], address[1:0]};

  assign sel       = (address[31:5] == BASE_ADDRESS[31:5]);
  assign ready     = sel;
  assign interrupt = irq_q;
  assign reg_idx   = address[4:2];
  assign wr_en     = sel & ~nwr[0];
  assign synced    = sync_q[SYNC_STAGES-1];
  // level_q is the synced level one clock later; doubles as the edge detector's previous sample
  assign rise      = synced & ~level_q;
  assign w1c       = (wr_en && reg_idx == 3'd0) ? data_in[7:0] : 8'h00;

`ifdef TINY32_INTC_SOFT_IRQ_EN
  logic [7:0] soft_pend_q, soft_pend_d, swset;
  assign swset       = (wr_en && reg_idx == 3'd4) ? data_in[7:0] : 8'h00;
  assign soft_pend_d = (soft_pend_q & ~w1c & ~ack_clr) | swset;
  assign soft_pend   = soft_pend_q;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) soft_pend_q <= 8'h00;
    else         soft_pend_q <= soft_pend_d;
  end
`else
  assign soft_pend = 8'h00;
`endif

  // A fresh rising edge wins over a same-cycle W1C or ack clear
  assign edge_pend_d = (edge_pend_q & ~w1c & ~ack_clr) | (rise & edge_q);
  assign pending     = (edge_pend_q & edge_q) | (level_q & ~edge_q) | soft_pend;
  assign cand        = pending & enable_q;

  always_comb begin
    onehot = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) begin
        onehot    = 8'h00;
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    active_d = active_q;
    ack_clr  = 8'h00;
    unique case (state_q)
      StIdle: begin
        // A spurious ack holds off arbitration until it is released
        if (interrupt_ack == 8'h00 && cand != 8'h00) begin
          irq_d    = onehot;
          active_d = onehot;
          state_d  = StRequest;
        end
      end
      StRequest: begin
        if (interrupt_ack != 8'h00) begin
          ack_clr = active_q;
          irq_d   = 8'h00;
          state_d = StInService;
        end else if ((cand & active_q) == 8'h00) begin
          irq_d    = 8'h00;
          active_d = 8'h00;
          state_d  = StIdle;
        end
      end
      StInService: begin
        if (interrupt_ack == 8'h00) begin
          active_d = 8'h00;
          state_d  = StIdle;
        end
      end
      default: begin
        irq_d    = 8'h00;
        active_d = 8'h00;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q      <= '0;
      level_q     <= 8'h00;
      edge_pend_q <= 8'h00;
      enable_q    <= 8'h00;
      edge_q      <= 8'h00;
      irq_q       <= 8'h00;
      active_q    <= 8'h00;
      state_q     <= StIdle;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_in};
      level_q     <= synced;
      edge_pend_q <= edge_pend_d;
      irq_q       <= irq_d;
      active_q    <= active_d;
      state_q     <= state_d;
      if (wr_en && reg_idx == 3'd1) enable_q <= data_in[7:0];
      if (wr_en && reg_idx == 3'd2) edge_q   <= data_in[7:0];
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (reg_idx)
      3'd0:    rdata = pending;
      3'd1:    rdata = enable_q;
      3'd2:    rdata = edge_q;
      3'd3:    rdata = active_q;
      default: rdata = 8'h00;
    endcase
  end

  assign data_out = (sel && !nrd) ? {24'h000000, rdata} : 32'h0000_0000;

endmodule

// File: tb/tb_tiny32_intc.sv
// Scoreboard bench for tiny32_intc: stimulus queues expectations, a negedge monitor compares them.
module tb_tiny32_intc;
  localparam logic [31:0] Base = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        nreset;
  logic [7:0]  irq_in;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        nrd;
  logic [3:0]  nwr;
  logic        sel;
  logic        ready;
  logic [7:0]  interrupt;
  logic [7:0]  interrupt_ack;

  tiny32_intc #(
    .BASE_ADDRESS(Base),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .irq_in       (irq_in),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .nrd          (nrd),
    .nwr          (nwr),
    .sel          (sel),
    .ready        (ready),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 interrupt, 1 data_out, 2 sel
    string       name;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb_q[$];
  chk_t        cur;
  logic [31:0] act;
  int          n_chk  = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      case (cur.kind)
        0:       act = {24'h0, interrupt};
        1:       act = data_out;
        default: act = {31'h0, sel};
      endcase
      n_chk++;
      if (act !== cur.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_irq(string nm, logic [7:0] v);
    chk_t c;
    c.kind = 0; c.name = nm; c.exp = {24'h0, v};
    sb_q.push_back(c);
  endtask

  task automatic exp_sel(string nm, logic v);
    chk_t c;
    c.kind = 2; c.name = nm; c.exp = {31'h0, v};
    sb_q.push_back(c);
  endtask

  task automatic rd(string nm, int r, logic [7:0] v);
    chk_t c;
    address = Base + 32'(r * 4);
    nrd = 1'b0;
    c.kind = 1; c.name = nm; c.exp = {24'h0, v};
    sb_q.push_back(c);
    tick();
    nrd = 1'b1;
  endtask

  task automatic wr(int r, logic [7:0] v);
    address = Base + 32'(r * 4);
    data_in = {24'h0, v};
    nwr = 4'hE;
    tick();
    nwr = 4'hF;
  endtask

  initial begin
    nreset = 1'b0; irq_in = 8'h00; address = 32'h0; data_in = 32'h0;
    nrd = 1'b1; nwr = 4'hF; interrupt_ack = 8'h00;
    tick(2);
    exp_irq("rst_irq", 8'h00);
    rd("rst_pend", 0, 8'h00);
    rd("rst_en", 1, 8'h00);
    rd("rst_edge", 2, 8'h00);
    nreset = 1'b1;
    tick();

    // Single-cycle edge pulse on source 0
    wr(1, 8'h01);
    wr(2, 8'h01);
    exp_sel("sel_hit", 1'b1);
    rd("en_rb", 1, 8'h01);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick(2);
    exp_irq("t1_lat", 8'h00);
    tick();
    exp_irq("t1_req", 8'h01);
    rd("t1_act", 3, 8'h01);
    interrupt_ack = 8'h01;
    tick();
    exp_irq("t1_ack", 8'h00);
    rd("t1_pend", 0, 8'h00);
    interrupt_ack = 8'h00;
    tick();
    rd("t1_idle_act", 3, 8'h00);

    // Simultaneous edges on 2 and 6: highest first, then 2 after reti
    wr(1, 8'hFF);
    wr(2, 8'hFF);
    irq_in = 8'h44;
    tick(4);
    exp_irq("t2_req", 8'h40);
    rd("t2_pend", 0, 8'h44);
    interrupt_ack = 8'h40;
    tick();
    exp_irq("t2_ack", 8'h00);
    rd("t2_pend_ack", 0, 8'h04);
    interrupt_ack = 8'h00;
    tick();
    exp_irq("t2_exit", 8'h00);
    tick();
    exp_irq("t2_next", 8'h04);
    interrupt_ack = 8'h04;
    tick();
    interrupt_ack = 8'h00;
    tick(2);
    irq_in = 8'h00;
    rd("t2_pend_clr", 0, 8'h00);

    // Level source 3 re-requests after reti, then withdraws
    wr(1, 8'h08);
    wr(2, 8'h00);
    irq_in = 8'h08;
    tick(4);
    exp_irq("t3_req", 8'h08);
    rd("t3_pend", 0, 8'h08);
    interrupt_ack = 8'h08;
    tick();
    interrupt_ack = 8'h00;
    tick();
    exp_irq("t3_exit", 8'h00);
    tick();
    exp_irq("t3_rearm", 8'h08);
    irq_in = 8'h00;
    tick(3);
    exp_irq("t3_hold", 8'h08);
    tick();
    exp_irq("t3_drop", 8'h00);
    rd("t3_act", 3, 8'h00);

    // Masking a request, then W1C of the edge pending bit
    wr(2, 8'h20);
    wr(1, 8'h20);
    irq_in = 8'h20;
    tick(4);
    exp_irq("t4_req", 8'h20);
    rd("t4_act", 3, 8'h20);
    wr(1, 8'h00);
    tick();
    exp_irq("t4_mask", 8'h00);
    rd("t4_pend", 0, 8'h20);
    wr(0, 8'h20);
    rd("t4_w1c", 0, 8'h00);
    irq_in = 8'h00;

    // Software set on source 7
    wr(1, 8'h80);
    wr(4, 8'h80);
    exp_irq("t5_pre", 8'h00);
    tick();
`ifdef TINY32_INTC_SOFT_IRQ_EN
    exp_irq("t5_soft", 8'h80);
    rd("t5_swset_rd", 4, 8'h00);
    interrupt_ack = 8'h80;
    tick();
    interrupt_ack = 8'h00;
    tick();
`else
    exp_irq("t5_soft", 8'h00);
    rd("t5_swset_rd", 4, 8'h00);
`endif
    rd("t5_pend", 0, 8'h00);

    // Unused register and out-of-window access
    wr(5, 8'hFF);
    rd("r5_rd", 5, 8'h00);
    address = 32'h1000_0000;
    nrd = 1'b0;
    exp_sel("sel_miss", 1'b0);
    begin
      chk_t c;
      c.kind = 1; c.name = "miss_data"; c.exp = 32'h0;
      sb_q.push_back(c);
    end
    tick();
    nrd = 1'b1;
    tick(2);

    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
